// File: rtl/stream_width_downsizer.sv
// Splits each upstream word into OUT_WIDTH-wide beats, lane 0 first, emitting only the valid lanes.
// Holds at most one word; the next word is accepted on the final-lane beat so packets flow without bubbles.
module stream_width_downsizer #(
  parameter int IN_WIDTH  = 64,
  parameter int OUT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [IN_WIDTH-1:0]  s_data,
  input  logic [3:0]           s_lanes,
  input  logic                 s_last,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [OUT_WIDTH-1:0] m_data,
  output logic                 m_last,
  output logic [15:0]          word_count,
  output logic [15:0]          pkt_count
);

  localparam int LANES = IN_WIDTH / OUT_WIDTH;
  localparam int IDX_W = (LANES > 1) ? $clog2(LANES) : 1;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic [IN_WIDTH-1:0]   word_q, word_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [IDX_W-1:0]      last_idx_q, last_idx_d;
  logic                  last_q, last_d;
  logic [15:0]           word_count_q, word_count_d;
  logic [15:0]           pkt_count_q, pkt_count_d;

  logic                  on_final_lane;
  logic                  up_xfer;
  logic                  dn_xfer;
  logic [OUT_WIDTH-1:0]  lane_data;

  // Out-of-range lane counts (0 or more than fit in a word) mean "whole word".
  function automatic logic [IDX_W-1:0] final_lane_idx(input logic [3:0] lanes);
    if (lanes == 4'd0 || int'(lanes) > LANES) begin
      return IDX_W'(LANES - 1);
    end
    return IDX_W'(int'(lanes) - 1);
  endfunction

  assign on_final_lane = (idx_q == last_idx_q);
  assign lane_data     = word_q[idx_q * OUT_WIDTH +: OUT_WIDTH];

  // Downstream outputs come only from registered state.
  assign m_valid = (state_q == SEND);
  assign m_data  = (state_q == SEND) ? lane_data : '0;
  assign m_last  = (state_q == SEND) && last_q && on_final_lane;

  assign s_ready = (state_q == IDLE) || (m_ready && on_final_lane);

  assign up_xfer = s_valid && s_ready;
  assign dn_xfer = m_valid && m_ready;

  assign word_count = word_count_q;
  assign pkt_count  = pkt_count_q;

  always_comb begin
    state_d      = state_q;
    word_d       = word_q;
    idx_d        = idx_q;
    last_idx_d   = last_idx_q;
    last_d       = last_q;
    word_count_d = word_count_q + 16'(up_xfer);
    pkt_count_d  = pkt_count_q + 16'(dn_xfer && m_last);

    case (state_q)
      IDLE: begin
        if (up_xfer) begin
          state_d    = SEND;
          word_d     = s_data;
          idx_d      = '0;
          last_idx_d = final_lane_idx(s_lanes);
          last_d     = s_last;
        end
      end
      SEND: begin
        if (dn_xfer) begin
          if (!on_final_lane) begin
            idx_d = idx_q + 1'b1;
          end else if (up_xfer) begin
            word_d     = s_data;
            idx_d      = '0;
            last_idx_d = final_lane_idx(s_lanes);
            last_d     = s_last;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control state and counters; reset discards any held word.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      word_count_q <= '0;
      pkt_count_q  <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      word_count_q <= word_count_d;
      pkt_count_q  <= pkt_count_d;
    end
  end

  // Held word payload; only observed while in SEND, so it needs no reset.
  always_ff @(posedge clk) begin
    word_q     <= word_d;
    last_idx_q <= last_idx_d;
    last_q     <= last_d;
  end

endmodule

// File: tb/tb_stream_width_downsizer.sv
// Randomized and directed bench for stream_width_downsizer; a beat queue models the expected output stream.
module tb_stream_width_downsizer;

  logic        clk = 1'b0;
  logic        reset;
  logic        s_valid;
  logic        s_ready;
  logic [63:0] s_data;
  logic [3:0]  s_lanes;
  logic        s_last;
  logic        m_valid;
  logic        m_ready;
  logic [7:0]  m_data;
  logic        m_last;
  logic [15:0] word_count;
  logic [15:0] pkt_count;

  stream_width_downsizer #(.IN_WIDTH(64), .OUT_WIDTH(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_data     (s_data),
    .s_lanes    (s_lanes),
    .s_last     (s_last),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .m_last     (m_last),
    .word_count (word_count),
    .pkt_count  (pkt_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] d;
    logic       l;
  } beat_t;

  beat_t       exp_q[$];
  logic [15:0] exp_wc;
  logic [15:0] exp_pc;
  int          dn_beats;
  int          nchk;
  int          nfail;
  bit          mon_en;
  int          rdy_mode;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nchk++;
    if (obs !== exp) begin
      nfail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference: every accepted word appends its valid lanes to a beat queue.
  always @(negedge clk) begin
    if (mon_en) begin
      logic exp_ready;
      int   n;
      exp_ready = (exp_q.size() == 0) || (exp_q.size() == 1 && m_ready);
      check("m_valid", m_valid, exp_q.size() != 0);
      check("s_ready", s_ready, exp_ready);
      if (exp_q.size() != 0) begin
        check("m_data", m_data, exp_q[0].d);
        check("m_last", m_last, exp_q[0].l);
      end
      check("word_count", word_count, exp_wc);
      check("pkt_count", pkt_count, exp_pc);
      if (reset) begin
        exp_q.delete();
        exp_wc = '0;
        exp_pc = '0;
      end else begin
        if (exp_q.size() != 0 && m_ready) begin
          if (exp_q[0].l) exp_pc = exp_pc + 16'd1;
          void'(exp_q.pop_front());
          dn_beats++;
        end
        if (s_valid && exp_ready) begin
          exp_wc = exp_wc + 16'd1;
          n = (s_lanes == 0 || s_lanes > 8) ? 8 : int'(s_lanes);
          for (int i = 0; i < n; i++) begin
            exp_q.push_back({s_data[i*8 +: 8], s_last && (i == n - 1)});
          end
        end
      end
    end
  end

  // Downstream ready pattern: 0 = always, 1 = alternating, 2 = random.
  initial begin
    m_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        1:       m_ready = ~m_ready;
        2:       m_ready = ($urandom_range(0, 3) != 0);
        default: m_ready = 1'b1;
      endcase
    end
  end

  task automatic push_word(input logic [63:0] d, input logic [3:0] l, input logic last);
    logic acc;
    int   n;
    n = 0;
    s_valid = 1'b1;
    s_data  = d;
    s_lanes = l;
    s_last  = last;
    do begin
      @(negedge clk);
      acc = s_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!acc && n < 2000);
    if (!acc) check("push_timeout", 1'b0, 1'b1);
    s_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (exp_q.size() != 0) check("drain_timeout", 1'b0, 1'b1);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int cycles);
    reset = 1'b1;
    repeat (cycles) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    int target;
    int n;
    nchk     = 0;
    nfail    = 0;
    mon_en   = 1'b0;
    rdy_mode = 0;
    dn_beats = 0;
    exp_wc   = '0;
    exp_pc   = '0;
    s_valid  = 1'b0;
    s_data   = '0;
    s_lanes  = '0;
    s_last   = 1'b0;

    do_reset(2);
    mon_en = 1'b1;
    @(negedge clk);
    check("rst_m_valid", m_valid, 1'b0);
    check("rst_s_ready", s_ready, 1'b1);
    check("rst_m_data", m_data, 8'h00);
    check("rst_word_count", word_count, 16'd0);
    check("rst_pkt_count", pkt_count, 16'd0);
    @(posedge clk);
    #1;

    push_word(64'h0807060504030201, 4'd8, 1'b1);
    drain();
    check("single_pkt_count", pkt_count, 16'd1);

    push_word(64'h1817161514131211, 4'd8, 1'b0);
    push_word(64'h2827262524232221, 4'd8, 1'b1);
    drain();
    check("b2b_word_count", word_count, 16'd3);

    rdy_mode = 1;
    push_word(64'h0807060504030201, 4'd8, 1'b1);
    drain();
    rdy_mode = 0;

    push_word(64'h1122334455CCBBAA, 4'd3, 1'b0);
    push_word(64'hF8F7F6F5F4F3F2F1, 4'd0, 1'b1);
    push_word(64'h0F0E0D0C0B0A0908, 4'd12, 1'b1);
    drain();

    target = dn_beats + 3;
    push_word(64'h0807060504030201, 4'd8, 1'b1);
    n = 0;
    while (dn_beats < target && n < 200) begin
      @(posedge clk);
      n++;
    end
    #1;
    do_reset(1);
    @(negedge clk);
    check("midrst_m_valid", m_valid, 1'b0);
    check("midrst_m_data", m_data, 8'h00);
    repeat (4) @(posedge clk);
    #1;

    for (int w = 0; w < 300; w++) begin
      if ($urandom_range(0, 3) == 0) rdy_mode = $urandom_range(0, 2);
      push_word({$urandom, $urandom}, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
      if ($urandom_range(0, 40) == 0) do_reset(1);
    end
    rdy_mode = 0;
    drain();

    do_reset(1);
    for (int w = 0; w < 65535; w++) push_word(64'(w), 4'd1, 1'b1);
    check("pre_wrap_word_count", word_count, 16'hFFFF);
    push_word(64'hAB, 4'd1, 1'b1);
    check("wrap_word_count", word_count, 16'h0000);
    drain();
    check("wrap_pkt_count", pkt_count, 16'h0000);

    mon_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", nchk, nfail);
    $finish;
  end

endmodule
